// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the data-memory bus responder.
//   MEM_BE_W        number of byte lanes in a data word
//   WAIT_CNT_W      width of the wait-state down-counter (0..15)
//   t_mem_rsp_state responder FSM states
package risc_v_mike_pkg;

    localparam int unsigned MEM_BE_W   = 4;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } t_mem_rsp_state;

endpackage

// File: rtl/risc_v_mike_be_ram.sv
// Byte-enabled word RAM: synchronous write of selected lanes, combinational read.
// Contents are not reset.
//   clk    clock
//   we     write enable (lanes qualified by be)
//   be     byte-lane strobes, bit i -> wdata[8i+7:8i]
//   addr   word index shared by read and write
//   wdata  write data
//   rdata  read data at addr (combinational)
module risc_v_mike_be_ram
    import risc_v_mike_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned DATA_W      = 32,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [MEM_BE_W-1:0] be,
    input  logic [IDX_W-1:0]    addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int unsigned LANE_W = DATA_W / MEM_BE_W;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Lane-wise write; unselected lanes keep their previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(MEM_BE_W); i++) begin
                if (be[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/risc_v_mike_mem_bus_responder.sv
// Data-memory target behind the bus decoder. Accepts one word request at a time,
// waits WAIT_STATES cycles, commits it to the local RAM and returns a response.
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  request present            req_ready  high only in IDLE (from state)
//   req_addr   byte address               req_write  1 = write, 0 = read
//   req_be     write byte-lane strobes    req_wdata  write data
//   rsp_valid  response present (reg)     rsp_ready  initiator takes response
//   rsp_rdata  read data, 0 for writes/errors (reg)
//   rsp_error  misaligned or out-of-range address (reg)
module risc_v_mike_mem_bus_responder
    import risc_v_mike_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_write,
    input  logic [MEM_BE_W-1:0] req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_error
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned WAIT_LOAD = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
    // Span is one bit wider than the address so BASE+span never overflows.
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(4 * DEPTH_WORDS);

    t_mem_rsp_state          state_q;
    t_mem_rsp_state          state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q;

    logic [ADDR_W-1:0]       lat_addr;
    logic                    lat_write;
    logic [MEM_BE_W-1:0]     lat_be;
    logic [DATA_W-1:0]       lat_wdata;

    logic                    accept;
    logic                    commit;

    logic [ADDR_W-1:0]       c_addr;
    logic                    c_write;
    logic [MEM_BE_W-1:0]     c_be;
    logic [DATA_W-1:0]       c_wdata;
    logic [ADDR_W-1:0]       offset;
    logic                    c_err;
    logic [IDX_W-1:0]        idx;

    logic                    ram_we;
    logic [DATA_W-1:0]       ram_rdata;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-state control: ready, accept strobe and commit strobe (edge entering RESP).
    always_comb begin
        req_ready = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                commit    = req_valid && (WAIT_STATES == 0);
            end
            WAIT: begin
                commit = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    // Wait-state down-counter, loaded on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= WAIT_CNT_W'(WAIT_LOAD);
        end else if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WAIT_CNT_W'(1);
        end
    end

    // Request latch; payload registers need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= req_addr;
            lat_write <= req_write;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
        end
    end

    // With zero wait states the commit happens on the accept edge itself,
    // so the live request must feed the RAM while still in IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            c_addr  = req_addr;
            c_write = req_write;
            c_be    = req_be;
            c_wdata = req_wdata;
        end else begin
            c_addr  = lat_addr;
            c_write = lat_write;
            c_be    = lat_be;
            c_wdata = lat_wdata;
        end
    end

    // Range and alignment check; the index never wraps, out-of-range is an error.
    assign offset = c_addr - BASE_ADDR;
    assign c_err  = (c_addr[1:0] != 2'b00)
                 || (c_addr < BASE_ADDR)
                 || ({1'b0, offset} >= SPAN);
    assign idx    = offset[IDX_W+1:2];
    assign ram_we = commit && c_write && !c_err;

    risc_v_mike_be_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (c_be),
        .addr  (idx),
        .wdata (c_wdata),
        .rdata (ram_rdata)
    );

    // Response registers: captured at commit, held until the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (commit) begin
            rsp_valid <= 1'b1;
            rsp_error <= c_err;
            rsp_rdata <= (c_write || c_err) ? '0 : ram_rdata;
        end else if ((state_q == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_risc_v_mike_mem_bus_responder.sv
// Scoreboard bench for the data-memory responder (WAIT_STATES=1 main instance,
// WAIT_STATES=0 secondary instance for the zero-wait latency).
module tb_risc_v_mike_mem_bus_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    logic        r0_req_valid;
    logic        r0_req_ready;
    logic [31:0] r0_req_addr;
    logic        r0_req_write;
    logic [3:0]  r0_req_be;
    logic [31:0] r0_req_wdata;
    logic        r0_rsp_valid;
    logic        r0_rsp_ready;
    logic [31:0] r0_rsp_rdata;
    logic        r0_rsp_error;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    risc_v_mike_mem_bus_responder #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    risc_v_mike_mem_bus_responder #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_addr(r0_req_addr),
        .req_write(r0_req_write), .req_be(r0_req_be), .req_wdata(r0_req_wdata),
        .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready), .rsp_rdata(r0_rsp_rdata),
        .rsp_error(r0_rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Monitor: every response handshake pops the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
                    chk({e.name, "_err"}, 32'(rsp_error), 32'(e.err));
                end
            end
        end
    end

    // Present a request at the negedge; waits (bounded) for req_ready.
    task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [3:0] be,
                             input logic [31:0] wd);
        @(negedge clk);
        req_addr  = addr;
        req_write = wr;
        req_be    = be;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    endtask

    // Full transaction: latency counted from the accept cycle, response checked by monitor.
    task automatic xact(input string nm, input logic [31:0] addr, input logic wr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        lat = -1;
        exp_q.push_back('{exp_rd, exp_err, nm});
        drive_req(addr, wr, be, wd);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        chk({nm, "_lat"}, 32'(lat), 32'd2);
        for (int i = 0; i < 20 && rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_write    = 1'b0;
        req_be       = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        r0_req_valid = 1'b0;
        r0_req_addr  = '0;
        r0_req_write = 1'b0;
        r0_req_be    = '0;
        r0_req_wdata = '0;
        r0_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        rst = 1'b1;

        // Basic write/read
        xact("wr_full",  BASE + 32'd8, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0);
        xact("rd_full",  BASE + 32'd8, 1'b0, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0);

        // Byte strobes
        xact("wr_strb",  BASE + 32'd8, 1'b1, 4'b0101, 32'h1122_3344, 32'h0,         1'b0);
        xact("rd_strb",  BASE + 32'd8, 1'b0, 4'h0,    32'h0,         32'hDE22_BE44, 1'b0);
        xact("wr_be0",   BASE + 32'd8, 1'b1, 4'h0,    32'hFFFF_FFFF, 32'h0,         1'b0);
        xact("rd_be0",   BASE + 32'd8, 1'b0, 4'h3,    32'h0,         32'hDE22_BE44, 1'b0);

        // Boundaries and errors
        xact("wr_last",  BASE + 32'hFFC,  1'b1, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0);
        xact("rd_last",  BASE + 32'hFFC,  1'b0, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0);
        xact("rd_misal", BASE + 32'd2,    1'b0, 4'h0, 32'h0,         32'h0,         1'b1);
        xact("wr_oor",   BASE + 32'h1000, 1'b1, 4'hF, 32'h0BAD_0BAD, 32'h0,         1'b1);
        xact("rd_below", BASE - 32'd4,    1'b0, 4'h0, 32'h0,         32'h0,         1'b1);
        xact("wr_misal", BASE + 32'hA,    1'b1, 4'hF, 32'h0,         32'h0,         1'b1);
        xact("rd_keep8", BASE + 32'd8,    1'b0, 4'h0, 32'h0,         32'hDE22_BE44, 1'b0);
        xact("rd_keepL", BASE + 32'hFFC,  1'b0, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0);

        // Backpressure with a concurrent second request
        rsp_ready = 1'b0;
        exp_q.push_back('{32'hDE22_BE44, 1'b0, "bp_first"});
        drive_req(BASE + 32'd8, 1'b0, 4'h0, 32'h0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        chk("bp_lat", 32'(lat), 32'd2);
        exp_q.push_back('{32'hDE22_BE44, 1'b0, "bp_second"});
        req_addr  = BASE + 32'd8;
        req_write = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_rdata", rsp_rdata, 32'hDE22_BE44);
            chk("bp_hold_err",   32'(rsp_error), 32'd0);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_valid_drop", 32'(rsp_valid), 32'd0);
        chk("bp_hs_no_accept",  32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_accept_next", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_second_seen", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 20 && rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end

        // Reset during WAIT of a write: dropped, RAM keeps old word
        drive_req(BASE + 32'd8, 1'b1, 4'hF, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstw_in_wait", 32'(req_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("rstw_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_error", 32'(rsp_error), 32'd0);
        chk("rstw_rdata", rsp_rdata, 32'd0);
        chk("rstw_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        xact("rd_after_rst", BASE + 32'd8, 1'b0, 4'h0, 32'h0, 32'hDE22_BE44, 1'b0);

        // Zero-wait-state instance: response one cycle after accept
        @(negedge clk);
        chk("ws0_ready", 32'(r0_req_ready), 32'd1);
        r0_req_addr  = BASE + 32'd4;
        r0_req_write = 1'b1;
        r0_req_be    = 4'hF;
        r0_req_wdata = 32'h1234_5678;
        r0_req_valid = 1'b1;
        @(posedge clk);
        #1;
        r0_req_valid = 1'b0;
        chk("ws0_wr_lat",   32'(r0_rsp_valid), 32'd1);
        chk("ws0_wr_err",   32'(r0_rsp_error), 32'd0);
        chk("ws0_wr_rdata", r0_rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("ws0_hs_drop",  32'(r0_rsp_valid), 32'd0);
        chk("ws0_hs_ready", 32'(r0_req_ready), 32'd1);
        @(negedge clk);
        r0_req_write = 1'b0;
        r0_req_valid = 1'b1;
        @(posedge clk);
        #1;
        r0_req_valid = 1'b0;
        chk("ws0_rd_lat",   32'(r0_rsp_valid), 32'd1);
        chk("ws0_rd_rdata", r0_rsp_rdata, 32'h1234_5678);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
